lsu_store_buffer: RTL and testbench

Load/store unit between the MEM pipeline stage and the byte-addressed data memory. Queues stores in a small FIFO and retires them to memory in free cycles as word-wide read-modify-writes, because the memory writes all four bytes on every write. Serves loads with combinational memory read, store-to-load forwarding, and sign/zero extension. Produces a registered load result for WB.

---
 rtl/lsu_store_buffer_pkg.sv | 42 ++++
 rtl/lsu_sb_fifo.sv | 74 +++++++
 rtl/lsu_store_buffer.sv | 159 +++++++++++++++
 tb/tb_lsu_store_buffer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_store_buffer_pkg.sv
// Shared definitions for the LSU store buffer: access-length encodings,
// buffer entry layout, default depth, and the size/extension helpers.
// Optional feature macro: LSU_SB_FWD_EN (store-to-load forwarding).
package lsu_store_buffer_pkg;

    // Access length encoding, shared with the data memory port.
    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2
    } len_e;

    localparam int SB_DEPTH_DEFAULT = 4;

    // One buffered store: byte address, length code and data (low bytes significant).
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } sb_entry_t;

    // Number of bytes touched by an access of the given length code.
    function automatic logic [2:0] size_of_len(input logic [1:0] len);
        case (len)
            LEN_BYTE: size_of_len = 3'd1;
            LEN_HALF: size_of_len = 3'd2;
            default:  size_of_len = 3'd4;
        endcase
    endfunction

    // Sign- or zero-extend the low bytes of a load to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  len,
                                                input logic        sgn);
        case (len)
            LEN_BYTE: extend_load = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
            LEN_HALF: extend_load = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default:  extend_load = raw;
        endcase
    endfunction

endpackage

// File: rtl/lsu_sb_fifo.sv
// Store-buffer FIFO: entry storage, wrap-around pointers, occupancy count,
// full/empty flags, and a parallel view of every slot (entry, validity,
// age relative to the head) used by the load overlap search.
module lsu_sb_fifo
    import lsu_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_push,
    input  sb_entry_t                             i_push_entry,
    input  logic                                  i_pop,
    output sb_entry_t                             o_head,
    output sb_entry_t [DEPTH-1:0]                 o_entries,
    output logic [DEPTH-1:0]                      o_valid,
    output logic [DEPTH-1:0][$clog2(DEPTH)-1:0]   o_age,
    output logic                                  o_full,
    output logic                                  o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    sb_entry_t      r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    // A full buffer refuses a push even if the head leaves in the same cycle.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Entry storage: written at the tail only; validity is tracked by the count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Parallel slot view: age 0 is the head (oldest), age count-1 the youngest.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
        assign o_entries[gi] = r_mem[gi];
        assign o_age[gi]     = PW'(gi) - r_rd_ptr;
        assign o_valid[gi]   = ({1'b0, o_age[gi]} < r_count);
    end

endmodule

// File: rtl/lsu_store_buffer.sv
// LSU store buffer: queues stores and retires them as word-wide
// read-modify-writes whenever no load needs the memory port; serves loads
// from memory (or from the buffer when forwarding is built in) with
// sign/zero extension and a registered result.
// Optional feature macro: LSU_SB_FWD_EN (store-to-load forwarding).
module lsu_store_buffer
    import lsu_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_len,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_load_valid,
    output logic        o_sb_empty,
    output logic        o_dm_we,
    output logic [1:0]  o_dm_len,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    input  logic [31:0] i_dm_rdata
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t                 w_head;
    sb_entry_t [DEPTH-1:0]     w_entries;
    sb_entry_t                 w_push_entry;
    logic [DEPTH-1:0]          w_valid;
    logic [DEPTH-1:0][PW-1:0]  w_age;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_is_store;
    logic                      w_is_load;
    logic                      w_store_stall;
    logic                      w_load_stall;
    logic                      w_load_accept;
    logic                      w_push;
    logic                      w_pop;
    logic [32:0]               w_ld_end;
    logic [DEPTH-1:0]          w_overlap;
    logic                      w_yng_found;
    logic [PW-1:0]             w_yng_idx;
    logic [PW-1:0]             w_yng_age;
    logic                      w_fwd_hit;
    logic [31:0]               w_load_raw;
    logic [31:0]               w_merge_data;
    logic [2:0]                w_head_size;
    logic                      r_load_valid;
    logic [31:0]               r_load_data;

    assign w_is_store   = i_req_valid & i_req_we;
    assign w_is_load    = i_req_valid & ~i_req_we;
    assign w_push_entry = '{addr: i_req_addr, len: i_req_len, data: i_req_wdata};

    lsu_sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_entries    (w_entries),
        .o_valid      (w_valid),
        .o_age        (w_age),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Byte-range overlap of the load against every valid entry; 33-bit ends avoid wrap.
    assign w_ld_end = {1'b0, i_req_addr} + 33'(size_of_len(i_req_len));
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_overlap
        logic [32:0] w_ent_end;
        assign w_ent_end     = {1'b0, w_entries[gi].addr} + 33'(size_of_len(w_entries[gi].len));
        assign w_overlap[gi] = w_valid[gi]
                             && ({1'b0, w_entries[gi].addr} < w_ld_end)
                             && ({1'b0, i_req_addr} < w_ent_end);
    end

    // Pick the youngest overlapping entry; it alone decides forward vs. stall.
    always_comb begin
        w_yng_found = 1'b0;
        w_yng_idx   = '0;
        w_yng_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_overlap[i] && (!w_yng_found || (w_age[i] > w_yng_age))) begin
                w_yng_found = 1'b1;
                w_yng_idx   = PW'(i);
                w_yng_age   = w_age[i];
            end
        end
    end

`ifdef LSU_SB_FWD_EN
    // Forward only when the youngest overlapping store starts at the load address
    // and covers every byte of it; older stores are then fully shadowed.
    assign w_fwd_hit = w_yng_found
                     && (w_entries[w_yng_idx].addr == i_req_addr)
                     && (size_of_len(w_entries[w_yng_idx].len) >= size_of_len(i_req_len));
`else
    assign w_fwd_hit = 1'b0;
`endif

    assign w_load_raw    = w_fwd_hit ? w_entries[w_yng_idx].data : i_dm_rdata;
    assign w_store_stall = w_is_store & w_full;
    assign w_load_stall  = w_is_load & w_yng_found & ~w_fwd_hit;
    assign w_load_accept = w_is_load & ~w_load_stall;
    assign w_push        = w_is_store & ~w_full;
    // Drain whenever an accepted load is not holding the port; a stalled load drains.
    assign w_pop         = ~w_load_accept & ~w_empty;
    assign o_stall       = w_store_stall | w_load_stall;
    assign o_sb_empty    = w_empty;

    // Read-modify-write data: head's low bytes over the current memory word.
    assign w_head_size = size_of_len(w_head.len);
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign w_merge_data[8*gi +: 8] = (3'(gi) < w_head_size) ? w_head.data[8*gi +: 8]
                                                                : i_dm_rdata[8*gi +: 8];
    end

    // Memory port arbitration: accepted load first, otherwise drain the head.
    always_comb begin
        o_dm_we    = 1'b0;
        o_dm_len   = LEN_WORD;
        o_dm_addr  = w_head.addr;
        o_dm_wdata = w_merge_data;
        if (w_load_accept) begin
            o_dm_len  = i_req_len;
            o_dm_addr = i_req_addr;
        end else if (!w_empty) begin
            o_dm_we = 1'b1;
        end
    end

    // Registered load result for write-back: one-cycle valid pulse per accepted load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_load_valid <= w_load_accept;
            if (w_load_accept) begin
                r_load_data <= extend_load(w_load_raw, i_req_len, i_req_signed);
            end
        end
    end

    assign o_load_valid = r_load_valid;
    assign o_load_data  = r_load_data;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Testbench for lsu_store_buffer: byte-array memory model on the dm port,
// directed scenarios followed by randomized loads/stores, all checked
// against a program-order reference (architectural memory + pending-store queue).
module tb_lsu_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_len;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        sb_empty;
    logic        dm_we;
    logic [1:0]  dm_len;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    // Back-door preload port into the environment memory.
    logic        bk_we;
    logic [7:0]  bk_addr;
    logic [31:0] bk_data;

    logic [7:0]  mem [256];       // environment memory seen by the DUT
    logic [7:0]  ref_mem [256];   // architectural memory: all accepted stores applied in order

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } st_t;
    st_t q[$];                    // stores accepted but not yet written to memory

    int n_checks = 0;
    int n_pass   = 0;

    lsu_store_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_we     (req_we),
        .i_req_len    (req_len),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_stall      (stall),
        .o_load_data  (load_data),
        .o_load_valid (load_valid),
        .o_sb_empty   (sb_empty),
        .o_dm_we      (dm_we),
        .o_dm_len     (dm_len),
        .o_dm_addr    (dm_addr),
        .o_dm_wdata   (dm_wdata),
        .i_dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    // Combinational little-endian read of four bytes at dm_addr.
    assign dm_rdata = {mem[dm_addr[7:0] + 8'd3], mem[dm_addr[7:0] + 8'd2],
                       mem[dm_addr[7:0] + 8'd1], mem[dm_addr[7:0]]};

    // Memory write: the DUT always writes all four bytes.
    always @(posedge clk) begin
        if (dm_we) begin
            for (int k = 0; k < 4; k++) mem[dm_addr[7:0] + 8'(k)] <= dm_wdata[8*k +: 8];
        end else if (bk_we) begin
            for (int k = 0; k < 4; k++) mem[bk_addr + 8'(k)] <= bk_data[8*k +: 8];
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int m_size(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_overlap(input st_t e, input logic [31:0] a, input int sz);
        longint e_lo, l_lo;
        e_lo = longint'(e.addr);
        l_lo = longint'(a);
        return (e_lo < l_lo + sz) && (l_lo < e_lo + m_size(e.len));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] len, input logic sgn);
        logic [31:0] v;
        int sz;
        sz = m_size(len);
        v  = '0;
        for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[a[7:0] + 8'(k)]) << (8*k));
        if (sgn && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
        for (int k = 0; k < m_size(len); k++) ref_mem[a[7:0] + 8'(k)] = d[8*k +: 8];
    endtask

    function automatic logic [31:0] env_word(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    task automatic bk_write(input logic [7:0] a, input logic [31:0] w);
        req_valid = 1'b0;
        bk_we = 1'b1; bk_addr = a; bk_data = w;
        @(posedge clk); #1;
        bk_we = 1'b0;
        for (int k = 0; k < 4; k++) ref_mem[a + 8'(k)] = w[8*k +: 8];
    endtask

    // One clock cycle: drive a request, predict and check the combinational
    // response, advance the model, then check the registered load result.
    task automatic cycle(input logic v, input logic we, input logic [1:0] len, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic acc, output logic [31:0] ld);
        logic exp_stall, exp_drain, ld_acc;
        logic [31:0] exp_ld;
        int sz;
        st_t e;
        req_valid = v; req_we = we; req_len = len; req_signed = sgn; req_addr = a; req_wdata = wd;
        @(negedge clk);
        exp_stall = 1'b0;
        sz = m_size(len);
        if (v && we) begin
            exp_stall = (q.size() == DEPTH);
        end else if (v) begin
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (m_overlap(q[k], a, sz)) begin
                    exp_stall = 1'b1;
`ifdef LSU_SB_FWD_EN
                    if (q[k].addr == a && m_size(q[k].len) >= sz) exp_stall = 1'b0;
`endif
                    break;
                end
            end
        end
        ld_acc    = v && !we && !exp_stall;
        exp_drain = !ld_acc && (q.size() != 0);
        exp_ld    = m_load(a, len, sgn);
        check_eq("stall", 32'(stall), 32'(exp_stall));
        check_eq("dm_we", 32'(dm_we), 32'(exp_drain));
        check_eq("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        if (exp_drain) check_eq("dm_addr_drain", dm_addr, q[0].addr);
        if (ld_acc) check_eq("dm_addr_load", dm_addr, a);
        @(posedge clk);
        if (exp_drain) void'(q.pop_front());
        if (v && we && !exp_stall) begin
            e.addr = a; e.len = len; e.data = wd;
            q.push_back(e);
            m_store(a, len, wd);
        end
        #1;
        check_eq("load_valid", 32'(load_valid), 32'(ld_acc));
        if (ld_acc) check_eq("load_data", load_data, exp_ld);
        acc = v && !exp_stall;
        ld  = load_data;
    endtask

    task automatic idle(input int n);
        logic acc;
        logic [31:0] ld;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, acc, ld);
    endtask

    // Present one operation until accepted (bounded retries).
    task automatic issue(input logic we, input logic [1:0] len, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int tries, output logic [31:0] ld);
        logic acc;
        tries = 0;
        acc   = 1'b0;
        ld    = '0;
        while (!acc && tries < 32) begin
            cycle(1'b1, we, len, sgn, a, wd, acc, ld);
            tries++;
        end
        check_eq("accepted", 32'(acc), 32'd1);
        $display("%s addr=%h len=%0d sgn=%0d wdata=%h tries=%0d load_data=%h",
                 we ? "ST" : "LD", a, len, sgn, wd, tries, we ? 32'd0 : ld);
    endtask

    initial begin
        int          tries;
        logic [31:0] ld;
        logic [31:0] a;
        logic [1:0]  len;
        logic        sg;

        clk = 1'b0; rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_len = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;

        // Reset state.
        #2;
        check_eq("rst_load_valid", 32'(load_valid), 32'd0);
        check_eq("rst_load_data", load_data, 32'd0);
        check_eq("rst_sb_empty", 32'(sb_empty), 32'd1);
        check_eq("rst_dm_we", 32'(dm_we), 32'd0);

        @(posedge clk); #1;
        for (int w = 0; w < 64; w++) bk_write(8'(w * 4), $urandom);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store drains one cycle later; bytes land little-endian.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, tries, ld);
        idle(2);
        check_eq("t1_mem_word", env_word(8'h10), 32'h11223344);
        check_eq("t1_sb_empty", 32'(sb_empty), 32'd1);

        // Byte store read-modify-writes only its own byte.
        bk_write(8'h20, 32'hAABBCCDD);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000005A, tries, ld);
        idle(2);
        check_eq("t2_mem_word", env_word(8'h20), 32'hAABB5ADD);

        // Back-to-back stores then loads sharing the port.
        for (int i = 0; i < 4; i++) issue(1'b1, 2'd2, 1'b0, 32'(32'h70 + 4*i), $urandom, tries, ld);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, tries, ld);
        issue(1'b1, 2'd2, 1'b0, 32'h74, 32'h5555AAAA, tries, ld);
        idle(2);

        // Half store then immediate signed half load of the same address.
        issue(1'b1, 2'd1, 1'b0, 32'h30, 32'h00008001, tries, ld);
        issue(1'b0, 2'd1, 1'b1, 32'h30, 32'd0, tries, ld);
        check_eq("t4_load_data", ld, 32'hFFFF8001);
`ifdef LSU_SB_FWD_EN
        check_eq("t4_tries", 32'(tries), 32'd1);
`else
        check_eq("t4_tries", 32'(tries), 32'd2);
`endif
        idle(2);

        // Partial overlap: word load must wait for the byte store to drain.
        bk_write(8'h40, 32'h03020100);
        issue(1'b1, 2'd0, 1'b0, 32'h41, 32'h00000077, tries, ld);
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, tries, ld);
        check_eq("t5_tries", 32'(tries), 32'd2);
        check_eq("t5_load_data", ld, 32'h03027700);

        // Byte extension.
        bk_write(8'h50, 32'h00000080);
        issue(1'b0, 2'd0, 1'b1, 32'h50, 32'd0, tries, ld);
        check_eq("t6_signed_byte", ld, 32'hFFFFFF80);
        issue(1'b0, 2'd0, 1'b0, 32'h50, 32'd0, tries, ld);
        check_eq("t6_unsigned_byte", ld, 32'h00000080);

        // Reset with a store still buffered: it is lost, the earlier one stays.
        bk_write(8'h64, 32'hCAFEF00D);
        issue(1'b1, 2'd2, 1'b0, 32'h60, 32'h12345678, tries, ld);
        issue(1'b1, 2'd2, 1'b0, 32'h64, 32'h0BADBEEF, tries, ld);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sb_empty", 32'(sb_empty), 32'd1);
        check_eq("mid_rst_dm_we", 32'(dm_we), 32'd0);
        check_eq("mid_rst_load_data", load_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        q.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 256; k++) ref_mem[k] = mem[k];
        check_eq("mid_rst_kept", env_word(8'h60), 32'h12345678);
        check_eq("mid_rst_lost", env_word(8'h64), 32'hCAFEF00D);

        // Randomized mix of loads, stores and idle cycles.
        for (int n = 0; n < 300; n++) begin
            int r;
            r   = int'($urandom_range(0, 9));
            a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 127))
                                              : 32'(32'h40 + $urandom_range(0, 11));
            len = 2'($urandom_range(0, 2));
            sg  = 1'($urandom_range(0, 1));
            if (r < 1)      idle(1);
            else if (r < 5) issue(1'b1, len, 1'b0, a, $urandom, tries, ld);
            else            issue(1'b0, len, sg, a, 32'd0, tries, ld);
        end

        // Let the buffer empty, then memory must equal the program-order view.
        idle(4);
        check_eq("final_sb_empty", 32'(sb_empty), 32'd1);
        for (int w = 0; w < 34; w++) check_eq("final_mem", env_word(8'(w * 4)), ref_word(8'(w * 4)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
